cpu_mc_core: RTL and testbench
==============================

CPU_MC_CORE -- requirements
Module: cpu_mc_core

Interface
REQ-001 Parameter D, default 12: program counter width in bits.
REQ-002 Parameter W, default 8: datapath and register width in bits.
REQ-003 Parameter RA, default 3: register address width; register file holds 2**RA registers.
REQ-004 Parameter END_PC, default 128: PC value that terminates a run.
REQ-005 Derived IW = 3+2*RA is the instruction width, and the fields SHALL be as follows:
- op = instr[IW-1:IW-3]
- ra = instr[2*RA-1:RA]
- rb = instr[RA-1:0]
REQ-006 clk, input, 1: single clock; all state updates on rising edge.
REQ-007 rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 start, input, 1: level; sampled in IDLE to begin a run.
REQ-009 start_pc, input, D: PC loaded when a run begins.
REQ-010 imem_addr, output, D: instruction address, equal to PC register.
REQ-011 imem_data, input, IW: instruction, valid one cycle after imem_addr is presented.
REQ-012 dmem_addr, output, W: data address.
REQ-013 dmem_wdata, output, W: store data.
REQ-014 dmem_we, output, 1: one-cycle store strobe.
REQ-015 dmem_rdata, input, W: load data, valid one cycle after dmem_addr is presented.
REQ-016 busy, output, 1: high in every state except IDLE and DONE.
REQ-017 done, output, 1: high while in DONE.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, EXEC, MEM, DONE.
REQ-019 IDLE with start=1 SHALL load PC<=start_pc and go to FETCH; with start=0 it SHALL stay in IDLE.
REQ-020 FETCH SHALL present PC on imem_addr, then go to EXEC next cycle; EXEC latches imem_data.
REQ-021 EXEC SHALL decode and execute op on R[ra] and R[rb], each treated as a W-bit value.
REQ-022 op 0 ADD: R[ra]<=R[ra]+R[rb], result modulo 2**W, carry discarded.
REQ-023 op 1 SUB: R[ra]<=R[ra]-R[rb], result modulo 2**W.
REQ-024 op 2 AND, op 3 XOR: bitwise, result written to R[ra].
REQ-025 op 4 LDI: R[ra]<=rb zero-extended to W bits.
REQ-026 op 5 LD: in EXEC, dmem_addr<=R[rb] and go to MEM; in MEM, R[ra]<=dmem_rdata.
REQ-027 op 6 ST: dmem_addr=R[rb], dmem_wdata=R[ra], dmem_we=1 for exactly the EXEC cycle.
REQ-028 op 7 BRZ: when R[ra]==0, PC<=PC+sext(rb) modulo 2**D; otherwise PC<=PC+1.
REQ-029 BRZ with rb==0 and R[ra]==0 (branch-to-self) SHALL be HALT and go to DONE; PC is unchanged.
REQ-030 All non-BRZ ops SHALL set PC<=PC+1 (modulo 2**D) at the end of EXEC (ALU ops, LDI, ST) or MEM (LD).
REQ-031 After the PC update, when the new PC==END_PC the core SHALL go to DONE; otherwise it goes to FETCH.
REQ-032 CPI SHALL be 2 for ALU, LDI, ST and BRZ, and 3 for LD.
REQ-033 dmem_we SHALL never be high outside EXEC of an ST instruction.
REQ-034 Register file writes SHALL occur only in EXEC (ALU ops, LDI) or MEM (LD); ra==rb is legal and reads the pre-write value.
REQ-035 DONE SHALL hold until start is low, then go to IDLE; start held high SHALL not restart a run.
REQ-036 start asserted while busy SHALL be ignored.
REQ-037 PC wrap from 2**D-1 SHALL go to 0 with no error, unless 0==END_PC, in which case the core goes to DONE.

Reset
REQ-038 rst_n low SHALL immediately force the following, regardless of the current state, including mid-instruction:
- state=IDLE
- PC=0
- all registers=0
- dmem_we=0, busy=0, done=0
REQ-039 dmem_addr and dmem_wdata SHALL be 0 in reset.
REQ-040 After rst_n rises, the core SHALL remain in IDLE until start is sampled high.

Verification
REQ-041 Reset then start=1, start_pc=0, program "LDI r1,5; LDI r2,3; ADD r1,r2; HALT(BRZ r0,0)" -> r1=8, done=1 after 8 cycles of busy.
REQ-042 Program "LDI r1,1; LDI r2,2; SUB r1,r2" -> r1=0xFF for W=8; wrapping verified with D=4, start_pc=15 -> next PC=0.
REQ-043 "LDI r3,6; LDI r4,2; ST r4,r3" then "LD r5,r3" -> dmem_we for one cycle with addr=6 and data=2; r5=2 after 3-cycle LD.
REQ-044 BRZ r1,-2 with r1!=0 -> PC+1; with r1==0 -> PC-2; BRZ to END_PC -> done=1.
REQ-045 rst_n pulsed low during MEM of an LD -> immediate IDLE, no register write, dmem_we=0, all registers 0.
REQ-046 start held high through DONE -> no restart; start low then high -> new run from start_pc.

Source files
------------

// File: rtl/cpu_mc_if.sv
// cpu_mc_if: bundle of the control, instruction-fetch and data-memory
// signals of the multi-cycle core.
// Ports / signals:
//   start, start_pc            run request and entry PC (host -> core)
//   imem_addr / imem_data      instruction fetch (data valid one cycle later)
//   dmem_addr / dmem_wdata     data address and store data
//   dmem_we                    one-cycle store strobe
//   dmem_rdata                 load data (valid one cycle after the address)
//   busy, done                 run status
// Modports: master = the core, slave = host plus memories.
interface cpu_mc_if #(
  parameter int D  = 12,
  parameter int W  = 8,
  parameter int RA = 3
);
  localparam int IW = 3 + 2 * RA;

  logic          start;
  logic [D-1:0]  start_pc;
  logic [D-1:0]  imem_addr;
  logic [IW-1:0] imem_data;
  logic [W-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic          dmem_we;
  logic [W-1:0]  dmem_rdata;
  logic          busy;
  logic          done;

  modport master (
    input  start, start_pc, imem_data, dmem_rdata,
    output imem_addr, dmem_addr, dmem_wdata, dmem_we, busy, done
  );

  modport slave (
    output start, start_pc, imem_data, dmem_rdata,
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we, busy, done
  );
endinterface

// File: rtl/cpu_mc_core.sv
// cpu_mc_core: small multi-cycle accumulator-free register machine.
// Every instruction goes FETCH -> EXEC, loads add a MEM cycle.
// Instruction format: op[IW-1:IW-3], ra[2*RA-1:RA], rb[RA-1:0].
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cpu_mc_if.master (start/start_pc in, imem/dmem buses, busy/done out)
module cpu_mc_core #(
  parameter int D      = 12,
  parameter int W      = 8,
  parameter int RA     = 3,
  parameter int END_PC = 128
) (
  input logic      clk,
  input logic      rst_n,
  cpu_mc_if.master bus
);
  localparam int IW = 3 + 2 * RA;
  localparam int NREG = 2 ** RA;
  localparam logic [D-1:0] EndPc = D'(END_PC);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpXor = 3'd3;
  localparam logic [2:0] OpLdi = 3'd4;
  localparam logic [2:0] OpLd  = 3'd5;
  localparam logic [2:0] OpSt  = 3'd6;
  localparam logic [2:0] OpBrz = 3'd7;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, DONE} state_e;

  state_e         state_q;
  logic [D-1:0]   pc_q;
  logic [W-1:0]   regs_q [NREG];
  logic [W-1:0]   dAddr_q;
  logic [RA-1:0]  ldDst_q;

  logic [2:0]     op;
  logic [RA-1:0]  ra;
  logic [RA-1:0]  rb;
  logic [W-1:0]   valA;
  logic [W-1:0]   valB;
  logic [W-1:0]   aluRes;
  logic [D-1:0]   pcInc;
  logic [D-1:0]   pcBr;
  logic [D-1:0]   pcNext;
  logic           isHalt;
  logic           isExec;

  // The instruction memory answers one cycle after FETCH, so during EXEC the
  // fields are decoded straight from imem_data.
  assign op   = bus.imem_data[IW-1:IW-3];
  assign ra   = bus.imem_data[2*RA-1:RA];
  assign rb   = bus.imem_data[RA-1:0];
  assign valA = regs_q[ra];
  assign valB = regs_q[rb];

  assign pcInc  = pc_q + 1'b1;
  assign pcBr   = pc_q + {{(D-RA){rb[RA-1]}}, rb};
  assign pcNext = (op == OpBrz && valA == '0) ? pcBr : pcInc;
  // A taken branch with zero offset would spin forever; treat it as HALT.
  assign isHalt = (op == OpBrz) && (rb == '0) && (valA == '0);

  // ALU result for the register-writing ops executed in EXEC.
  always_comb begin
    aluRes = '0;
    case (op)
      OpAdd:   aluRes = valA + valB;
      OpSub:   aluRes = valA - valB;
      OpAnd:   aluRes = valA & valB;
      OpXor:   aluRes = valA ^ valB;
      OpLdi:   aluRes = W'(rb);
      default: aluRes = '0;
    endcase
  end

  // The data address is driven during EXEC so a registered memory returns
  // load data in MEM; outside EXEC the last address is held. Status outputs
  // are decoded from the state register only.
  assign isExec         = (state_q == EXEC);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_we    = isExec && (op == OpSt);
  assign bus.dmem_addr  = (isExec && (op == OpLd || op == OpSt)) ? valB : dAddr_q;
  assign bus.dmem_wdata = bus.dmem_we ? valA : '0;
  assign bus.busy       = (state_q == FETCH) || (state_q == EXEC) || (state_q == MEM);
  assign bus.done       = (state_q == DONE);

  // Control FSM, PC and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      dAddr_q <= '0;
      ldDst_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            pc_q    <= bus.start_pc;
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= EXEC;
        EXEC: begin
          if (op == OpLd) begin
            dAddr_q <= valB;
            ldDst_q <= ra;
            state_q <= MEM;
          end else if (isHalt) begin
            state_q <= DONE;
          end else begin
            if (op == OpSt) dAddr_q <= valB;
            else if (op != OpBrz) regs_q[ra] <= aluRes;
            pc_q    <= pcNext;
            state_q <= (pcNext == EndPc) ? DONE : FETCH;
          end
        end
        MEM: begin
          regs_q[ldDst_q] <= bus.dmem_rdata;
          pc_q            <= pcInc;
          state_q         <= (pcInc == EndPc) ? DONE : FETCH;
        end
        DONE: begin
          // Leaving DONE needs start low, so a held start cannot re-launch.
          if (!bus.start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mc_core.sv
// tb_cpu_mc_core: scoreboard bench for cpu_mc_core (D=4, W=8, RA=3, END_PC=12).
// Stores and run completions are predicted into a queue by the stimulus and
// popped by an independent monitor; a few static values are checked directly.
module tb_cpu_mc_core;
  typedef struct {
    bit         isDone;
    logic [7:0] addr;
    logic [7:0] data;
    int         cycles;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t expQ[$];
  exp_t monExp;
  int   busyCnt;
  bit   doneSeen;

  logic [8:0] imem [16];
  logic [7:0] dmem [256];

  cpu_mc_if #(.D(4), .W(8), .RA(3)) bus ();

  cpu_mc_core #(.D(4), .W(8), .RA(3), .END_PC(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered instruction and data memories.
  always @(posedge clk) begin
    bus.imem_data <= imem[bus.imem_addr];
    if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    bus.dmem_rdata <= dmem[bus.dmem_addr];
  end

  // Monitor: pops the scoreboard on every store strobe and on each rising done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busyCnt  = 0;
      doneSeen = 1'b0;
    end else begin
      if (bus.busy) busyCnt++;
      if (bus.dmem_we) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL store: unexpected addr=%0h data=%0h", bus.dmem_addr, bus.dmem_wdata);
        end else begin
          monExp = expQ.pop_front();
          if (monExp.isDone || monExp.addr !== bus.dmem_addr || monExp.data !== bus.dmem_wdata) begin
            errors++;
            $display("[TB] FAIL store: got addr=%0h data=%0h, expected isDone=%0d addr=%0h data=%0h",
                     bus.dmem_addr, bus.dmem_wdata, monExp.isDone, monExp.addr, monExp.data);
          end
        end
      end
      if (bus.done && !doneSeen) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL done: unexpected completion pc=%0h", bus.imem_addr);
        end else begin
          monExp = expQ.pop_front();
          if (!monExp.isDone || monExp.addr !== {4'b0, bus.imem_addr} || monExp.cycles != busyCnt) begin
            errors++;
            $display("[TB] FAIL done: got pc=%0h busyCycles=%0d, expected isDone=%0d pc=%0h busyCycles=%0d",
                     bus.imem_addr, busyCnt, monExp.isDone, monExp.addr, monExp.cycles);
          end
        end
        busyCnt = 0;
      end
      doneSeen = bus.done;
    end
  end

  function automatic logic [8:0] enc(input int op, input int ra, input int rb);
    return {3'(op), 3'(ra), 3'(rb)};
  endfunction

  task automatic clearImem();
    for (int i = 0; i < 16; i++) imem[i] = enc(7, 0, 0);
  endtask

  task automatic pushStore(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.isDone = 1'b0; e.addr = a; e.data = d; e.cycles = 0;
    expQ.push_back(e);
  endtask

  task automatic pushDone(input logic [7:0] pc, input int cyc);
    exp_t e;
    e.isDone = 1'b1; e.addr = pc; e.data = '0; e.cycles = cyc;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Launch a run and wait (bounded) for done; optionally keep start high.
  task automatic applyStimulus(input logic [3:0] pc, input bit hold);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.start_pc = pc;
    bus.start    = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: done=%0d, expected 1 within 200 cycles", bus.done);
    end
    if (!hold) repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.start_pc = '0;
    clearImem();
    #1;
    checkOutput("rstBusy",  16'(bus.busy), 16'h0);
    checkOutput("rstDone",  16'(bus.done), 16'h0);
    checkOutput("rstWe",    16'(bus.dmem_we), 16'h0);
    checkOutput("rstPc",    16'(bus.imem_addr), 16'h0);
    checkOutput("rstDAddr", 16'(bus.dmem_addr), 16'h0);
    checkOutput("rstWData", 16'(bus.dmem_wdata), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleAfterReset", 16'(bus.busy), 16'h0);

    $display("[TB] LDI/ADD/HALT");
    clearImem();
    imem[0] = enc(4, 1, 5); imem[1] = enc(4, 2, 3); imem[2] = enc(0, 1, 2); imem[3] = enc(7, 0, 0);
    pushDone(8'd3, 8);
    applyStimulus(4'd0, 1'b0);
    clearImem();
    imem[0] = enc(6, 1, 0); imem[1] = enc(7, 0, 0);
    pushStore(8'd0, 8'd8);
    pushDone(8'd1, 4);
    applyStimulus(4'd0, 1'b0);

    $display("[TB] SUB wrap");
    clearImem();
    imem[0] = enc(4, 1, 1); imem[1] = enc(4, 2, 2); imem[2] = enc(1, 1, 2);
    imem[3] = enc(6, 1, 0); imem[4] = enc(7, 0, 0);
    pushStore(8'd0, 8'hFF);
    pushDone(8'd4, 10);
    applyStimulus(4'd0, 1'b0);

    $display("[TB] PC wrap, ST and LD");
    clearImem();
    imem[15] = enc(4, 3, 6); imem[0] = enc(4, 4, 2); imem[1] = enc(6, 4, 3);
    imem[2] = enc(5, 5, 3); imem[3] = enc(6, 5, 0); imem[4] = enc(7, 0, 0);
    pushStore(8'd6, 8'd2);
    pushStore(8'd0, 8'd2);
    pushDone(8'd4, 13);
    applyStimulus(4'd15, 1'b0);

    $display("[TB] BRZ not-taken/taken, start held while busy");
    clearImem();
    imem[0] = enc(4, 1, 1); imem[1] = enc(7, 1, -2); imem[2] = enc(7, 7, 3);
    imem[3] = enc(6, 1, 0); imem[4] = enc(7, 0, 0); imem[5] = enc(7, 7, -2);
    pushStore(8'd0, 8'd1);
    pushDone(8'd4, 12);
    applyStimulus(4'd0, 1'b1);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] BRZ to END_PC with start held through DONE");
    clearImem();
    imem[10] = enc(7, 7, 2);
    pushDone(8'd12, 2);
    applyStimulus(4'd10, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("holdDone", 16'(bus.done), 16'h1);
    checkOutput("holdBusy", 16'(bus.busy), 16'h0);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("releaseIdle", 16'(bus.done), 16'h0);

    $display("[TB] reset during MEM of LD");
    clearImem();
    imem[0] = enc(4, 2, 4); imem[1] = enc(4, 6, 5); imem[2] = enc(6, 6, 2); imem[3] = enc(7, 0, 0);
    pushStore(8'd4, 8'd5);
    pushDone(8'd3, 8);
    applyStimulus(4'd0, 1'b0);
    clearImem();
    imem[0] = enc(4, 2, 4); imem[1] = enc(5, 3, 2);
    @(negedge clk);
    bus.start_pc = 4'd0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("inMemAddr", 16'(bus.dmem_addr), 16'h4);
    checkOutput("inMemBusy", 16'(bus.busy), 16'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy",  16'(bus.busy), 16'h0);
    checkOutput("midRstDone",  16'(bus.done), 16'h0);
    checkOutput("midRstWe",    16'(bus.dmem_we), 16'h0);
    checkOutput("midRstPc",    16'(bus.imem_addr), 16'h0);
    checkOutput("midRstDAddr", 16'(bus.dmem_addr), 16'h0);
    checkOutput("midRstWData", 16'(bus.dmem_wdata), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleAfterMidRst", 16'(bus.busy), 16'h0);

    $display("[TB] register dump after reset");
    clearImem();
    for (int k = 0; k < 8; k++) begin
      imem[k] = enc(6, k, 0);
      pushStore(8'd0, 8'd0);
    end
    imem[8] = enc(7, 0, 0);
    pushDone(8'd8, 18);
    applyStimulus(4'd0, 1'b0);

    @(negedge clk);
    checkOutput("queueEmpty", 16'(expQ.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
